// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the 5-stage RV32I pipeline.
// Shadows D->E->M->W writes; drives forwarding, stall and flush controls.
module hazard_scoreboard #(
    parameter int AW         = 5,
    parameter int MULDIV_LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Valid_D,
    input  logic [AW-1:0] Rs1_D,
    input  logic [AW-1:0] Rs2_D,
    input  logic          UseRs1_D,
    input  logic          UseRs2_D,
    input  logic [AW-1:0] Rd_D,
    input  logic          RegWrite_D,
    input  logic          ResultSrc_D,
    input  logic          MulDiv_D,
    input  logic          PCSrc_E,
    output logic          StallF,
    output logic          StallD,
    output logic          StallE,
    output logic          FlushD,
    output logic          FlushE,
    output logic [1:0]    ForwardA_E,
    output logic [1:0]    ForwardB_E,
    output logic          Busy
);

    localparam int CW = $clog2(MULDIV_LAT) + 1;
    localparam logic [CW-1:0] LAT_M1 = CW'(MULDIV_LAT - 1);

    // E entry keeps source info; M/W only need write info
    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          use1;
        logic          use2;
        logic          regwrite;
        logic          load;
    } ent_e_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic          regwrite;
    } ent_w_t;

    ent_e_t        r_se;
    ent_w_t        r_sm;
    ent_w_t        r_sw;
    logic [CW-1:0] r_cnt;

    logic          w_busy;
    logic          w_lu;
    logic          w_se_hit1;
    logic          w_se_hit2;
    ent_e_t        w_d;
    ent_w_t        w_se_wb;

    function automatic logic f_match(
        input logic          v,
        input logic          rw,
        input logic [AW-1:0] rd,
        input logic [AW-1:0] r
    );
        return v & rw & (rd != '0) & (rd == r);
    endfunction

    function automatic logic [1:0] f_fwd(
        input ent_w_t        m,
        input ent_w_t        w,
        input logic          use_r,
        input logic [AW-1:0] r
    );
        if (use_r && f_match(m.valid, m.regwrite, m.rd, r))
            return 2'b10;
        else if (use_r && f_match(w.valid, w.regwrite, w.rd, r))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_busy    = (r_cnt != '0);
    assign w_se_hit1 = f_match(r_se.valid, r_se.regwrite, r_se.rd, Rs1_D);
    assign w_se_hit2 = f_match(r_se.valid, r_se.regwrite, r_se.rd, Rs2_D);
    assign w_lu      = r_se.load & Valid_D
                     & ((w_se_hit1 & UseRs1_D) | (w_se_hit2 & UseRs2_D));

    assign w_d = '{valid: Valid_D, rd: Rd_D, rs1: Rs1_D, rs2: Rs2_D,
                   use1: UseRs1_D, use2: UseRs2_D,
                   regwrite: RegWrite_D, load: ResultSrc_D};
    assign w_se_wb = '{valid: r_se.valid, rd: r_se.rd,
                       regwrite: r_se.regwrite};

    // Control outputs: busy hold > branch flush > load-use stall
    always_comb begin
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        ForwardA_E = 2'b00;
        ForwardB_E = 2'b00;
        Busy       = 1'b0;
        if (!rst) begin
            ForwardA_E = f_fwd(r_sm, r_sw, r_se.use1, r_se.rs1);
            ForwardB_E = f_fwd(r_sm, r_sw, r_se.use2, r_se.rs2);
            Busy       = w_busy;
            if (w_busy) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
            end else if (PCSrc_E) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (w_lu) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // Shadow pipeline and mul/div countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            r_se  <= '0;
            r_sm  <= '0;
            r_sw  <= '0;
            r_cnt <= '0;
        end else if (w_busy) begin
            r_sw  <= r_sm;
            r_sm  <= '0;
            r_cnt <= r_cnt - 1'b1;
        end else begin
            r_sw <= r_sm;
            r_sm <= w_se_wb;
            if (FlushE) begin
                r_se  <= '0;
                r_cnt <= '0;
            end else begin
                r_se  <= w_d;
                r_cnt <= (Valid_D && MulDiv_D) ? LAT_M1 : '0;
            end
        end
    end

endmodule
